// File: rtl/ad9837_sweep_seq_if.sv
// rtl/ad9837_sweep_seq_if.sv - frequency-write handshake between the sweep sequencer and the AD9837 SPI controller.
interface ad9837_sweep_seq_if;
  logic [27:0] FCODE;
  logic        fwrq;
  logic        fws;
  logic        fsel;
  logic        busy;

  modport master (output FCODE, output fwrq, output fws, output fsel, input busy);
  modport slave  (input FCODE, input fwrq, input fws, input fsel, output busy);
endinterface

// File: rtl/ad9837_sweep_seq.sv
// rtl/ad9837_sweep_seq.sv - AD9837 stepped frequency sweep sequencer.
// Define AD9837_SWEEP_PINGPONG_EN to alternate writes between FREQ0/FREQ1 and swap fsel after each write.
module ad9837_sweep_seq #(
  parameter int WR_TIMEOUT = 64,
  parameter int DWELL_W    = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [27:0]        f_start,
  input  logic [27:0]        f_step,
  input  logic [15:0]        n_steps,
  input  logic [DWELL_W-1:0] dwell,
  ad9837_sweep_seq_if.master ctl,
  output logic               active,
  output logic               done,
  output logic               err,
  output logic [15:0]        step_idx
);

  localparam int TO_W = $clog2(WR_TIMEOUT + 1);
  localparam logic [TO_W-1:0]    WR_LAST = TO_W'(WR_TIMEOUT - 1);
  localparam logic [TO_W-1:0]    TO_ONE  = 1;
  localparam logic [DWELL_W-1:0] DW_ONE  = 1;

  typedef enum logic [2:0] {IDLE, LOAD, WRQ, WAIT_DONE, SWAP, DWELL, FINISH} state_t;

  state_t state, state_nxt;

  logic [27:0]        f_start_q, f_step_q, fcode_q;
  logic [15:0]        n_steps_q, step_q;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt;
  logic [TO_W-1:0]    wr_cnt;
  logic               err_q, abort_pend;
  logic               accept, do_load, do_step, set_err, latch_abort, dwell_exp;

  // dwell=0 still spends one cycle in DWELL
  assign dwell_exp = (dwell_q == '0) || (dwell_cnt == dwell_q - DW_ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    do_load     = 1'b0;
    do_step     = 1'b0;
    set_err     = 1'b0;
    latch_abort = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        do_load   = 1'b1;
        state_nxt = abort ? IDLE : WRQ;
      end
      WRQ: begin
        // once busy is up the frame must complete, so abort is only remembered
        if (ctl.busy) begin
          latch_abort = abort;
          state_nxt   = WAIT_DONE;
        end else if (abort) begin
          state_nxt = IDLE;
        end else if (wr_cnt == WR_LAST) begin
          set_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        latch_abort = abort;
        if (!ctl.busy) state_nxt = (abort_pend || abort) ? IDLE : SWAP;
      end
      SWAP: state_nxt = abort ? IDLE : DWELL;
      DWELL: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (dwell_exp) begin
          if (step_q == n_steps_q) begin
            state_nxt = FINISH;
          end else begin
            do_step   = 1'b1;
            state_nxt = WRQ;
          end
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_start_q  <= '0;
      f_step_q   <= '0;
      n_steps_q  <= '0;
      dwell_q    <= '0;
      fcode_q    <= '0;
      step_q     <= '0;
      err_q      <= 1'b0;
      abort_pend <= 1'b0;
      wr_cnt     <= '0;
      dwell_cnt  <= '0;
    end else begin
      if (accept) begin
        f_start_q <= f_start;
        f_step_q  <= f_step;
        n_steps_q <= n_steps;
        dwell_q   <= dwell;
      end
      if (do_load) begin
        fcode_q    <= f_start_q;
        step_q     <= '0;
        err_q      <= 1'b0;
        abort_pend <= 1'b0;
      end
      if (do_step) begin
        fcode_q <= fcode_q + f_step_q;
        step_q  <= step_q + 16'd1;
      end
      if (set_err)     err_q      <= 1'b1;
      if (latch_abort) abort_pend <= 1'b1;
      wr_cnt    <= (state == WRQ)   ? wr_cnt + TO_ONE    : '0;
      dwell_cnt <= (state == DWELL) ? dwell_cnt + DW_ONE : '0;
    end
  end

`ifdef AD9837_SWEEP_PINGPONG_EN
  logic fws_q, fsel_q;

  // each write lands in the register not currently driving the output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fws_q  <= 1'b0;
      fsel_q <= 1'b0;
    end else begin
      if (do_load || do_step) fws_q  <= ~fsel_q;
      if (state == SWAP)      fsel_q <= fws_q;
    end
  end

  assign ctl.fws  = fws_q;
  assign ctl.fsel = fsel_q;
`else
  assign ctl.fws  = 1'b0;
  assign ctl.fsel = 1'b0;
`endif

  assign ctl.FCODE = fcode_q;
  assign ctl.fwrq  = (state == WRQ);
  assign active    = (state != IDLE);
  assign done      = (state == FINISH);
  assign err       = err_q;
  assign step_idx  = step_q;

endmodule

// File: tb/tb_ad9837_sweep_seq.sv
// tb/tb_ad9837_sweep_seq.sv - randomized self-checking bench for ad9837_sweep_seq with a reactive SPI controller model.
module tb_ad9837_sweep_seq;
`ifdef AD9837_SWEEP_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [27:0] f_start, f_step;
  logic [15:0] n_steps;
  logic [23:0] dwell;
  logic        active, done, err;
  logic [15:0] step_idx;

  ad9837_sweep_seq_if ctl();

  ad9837_sweep_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_steps(n_steps), .dwell(dwell),
    .ctl(ctl), .active(active), .done(done), .err(err), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // controller model: answers fwrq after a random latency, holds busy for busy_len cycles
  bit          dead = 1'b0;
  int          busy_len = 4, lat_min = 0, lat_max = 0;
  int          lat, bcnt, since_fall;
  logic [27:0] wr_fcode[$];
  logic        wr_fws[$];
  logic [15:0] wr_idx[$];
  int          wr_gap[$];

  initial begin
    ctl.busy = 1'b0;
    lat = -1; bcnt = 0; since_fall = 1000;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        ctl.busy = 1'b0; lat = -1; bcnt = 0;
      end else if (ctl.busy) begin
        bcnt--;
        if (bcnt <= 0) begin
          ctl.busy = 1'b0;
          since_fall = 0;
        end
      end else begin
        since_fall++;
        if (!ctl.fwrq || dead) begin
          lat = -1;
        end else begin
          if (lat < 0) begin
            lat = $urandom_range(lat_max, lat_min);
            wr_gap.push_back(since_fall);
          end
          if (lat == 0) begin
            ctl.busy = 1'b1;
            bcnt = busy_len;
            wr_fcode.push_back(ctl.FCODE);
            wr_fws.push_back(ctl.fws);
            wr_idx.push_back(step_idx);
            lat = -1;
          end else begin
            lat--;
          end
        end
      end
    end
  end

  // negedge monitor: done pulses, fwrq-high cycles, register changes during a write
  int          done_cnt = 0, fwrq_cycles = 0, unstable = 0;
  logic [27:0] p_fc = '0;
  logic        p_fws = 1'b0, p_fsel = 1'b0, p_fwrq = 1'b0, p_busy = 1'b0, p_rst = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (ctl.fwrq) fwrq_cycles++;
      if (reset && p_rst && (p_fwrq || p_busy) &&
          (ctl.FCODE != p_fc || ctl.fws != p_fws || ctl.fsel != p_fsel)) unstable++;
      p_fc = ctl.FCODE; p_fws = ctl.fws; p_fsel = ctl.fsel;
      p_fwrq = ctl.fwrq; p_busy = ctl.busy; p_rst = reset;
    end
  end

  bit m_fsel = 1'b0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_log();
    wr_fcode.delete(); wr_fws.delete(); wr_idx.delete(); wr_gap.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [27:0] fs, input logic [27:0] st,
                             input logic [15:0] n, input logic [23:0] dw);
    f_start = fs; f_step = st; n_steps = n; dwell = dw;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (active && k < bound) begin
      tick();
      k++;
    end
    check("idle_reached", {63'd0, active}, 64'd0);
  endtask

  task automatic wait_busy(input logic level, input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ctl.busy !== level && k < bound);
    check("busy_wait", {63'd0, ctl.busy}, {63'd0, level});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fcode"}, {36'd0, ctl.FCODE}, 64'd0);
    check({tag, "_fwrq"},  {63'd0, ctl.fwrq},  64'd0);
    check({tag, "_fws"},   {63'd0, ctl.fws},   64'd0);
    check({tag, "_fsel"},  {63'd0, ctl.fsel},  64'd0);
    check({tag, "_active"},{63'd0, active},    64'd0);
    check({tag, "_done"},  {63'd0, done},      64'd0);
    check({tag, "_err"},   {63'd0, err},       64'd0);
    check({tag, "_idx"},   {48'd0, step_idx},  64'd0);
  endtask

  // full sweep compared against f_start + k*f_step (mod 2^28) for k = 0..n_steps
  task automatic run_sweep(input logic [27:0] fs, input logic [27:0] st,
                           input logic [15:0] n, input logic [23:0] dw);
    logic [63:0] exp_fc;
    logic        exp_fws;
    int          d;
    clear_log();
    pulse_start(fs, st, n, dw);
    tick();
    check("err_cleared", {63'd0, err}, 64'd0);
    check("active_up",   {63'd0, active}, 64'd1);
    wait_idle(20000);
    check("n_writes", 64'(wr_fcode.size()), 64'(int'(n) + 1));
    d = (dw == 0) ? 1 : int'(dw);
    for (int k = 0; k <= int'(n) && k < wr_fcode.size(); k++) begin
      exp_fc  = (64'(fs) + 64'(k) * 64'(st)) & 64'h0FFF_FFFF;
      exp_fws = PP ? ~m_fsel : 1'b0;
      check($sformatf("fcode[%0d]", k), {36'd0, wr_fcode[k]}, exp_fc);
      check($sformatf("fws[%0d]", k),   {63'd0, wr_fws[k]},   {63'd0, exp_fws});
      check($sformatf("idx[%0d]", k),   {48'd0, wr_idx[k]},   64'(k));
      if (k > 0 && k < wr_gap.size())
        check($sformatf("gap[%0d]", k), 64'(wr_gap[k]), 64'(d + 2));
      m_fsel = exp_fws;
    end
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("err_end",     {63'd0, err}, 64'd0);
    check("fsel_end",    {63'd0, ctl.fsel}, {63'd0, m_fsel});
  endtask

  logic [27:0] fc_hold;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    f_start = '0; f_step = '0; n_steps = '0; dwell = '0;
    repeat (3) tick();
    check_zero("rst");
    reset = 1'b1;
    tick();

    busy_len = 40;
    run_sweep(28'h0008312, 28'h100, 16'd3, 24'd10);

    busy_len = 3;
    run_sweep(28'hFFFFFF0, 28'h20, 16'd1, 24'd2);
    run_sweep(28'h1234567, 28'h11, 16'd0, 24'd0);

    lat_max = 3;
    for (int i = 0; i < 8; i++) begin
      busy_len = $urandom_range(8, 1);
      run_sweep(28'($urandom), 28'($urandom), 16'($urandom_range(4, 0)), 24'($urandom_range(12, 0)));
    end

    // no busy ever: timeout after WR_TIMEOUT cycles of fwrq
    dead = 1'b1; fwrq_cycles = 0; clear_log();
    pulse_start(28'h0000100, 28'h1, 16'd2, 24'd3);
    wait_idle(300);
    check("to_fwrq_cycles", 64'(fwrq_cycles), 64'd64);
    check("to_err",  {63'd0, err}, 64'd1);
    check("to_done", 64'(done_cnt), 64'd0);
    dead = 1'b0;
    busy_len = 5;
    run_sweep(28'h0ABCDEF, 28'h300, 16'd2, 24'd4);

    // abort five cycles into a busy frame
    busy_len = 30; lat_max = 0; clear_log();
    pulse_start(28'h0000500, 28'h10, 16'd3, 24'd5);
    wait_busy(1'b1, 200);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b1; fc_hold = ctl.FCODE; fwrq_cycles = 0;
    tick();
    abort = 1'b0;
    wait_idle(200);
    check("ab_busy_fcode", {36'd0, ctl.FCODE}, {36'd0, fc_hold});
    check("ab_busy_fwrq",  64'(fwrq_cycles), 64'd0);
    check("ab_busy_done",  64'(done_cnt), 64'd0);
    check("ab_busy_nwr",   64'(wr_fcode.size()), 64'd1);
    check("ab_busy_fsel",  {63'd0, ctl.fsel}, {63'd0, m_fsel});

    // abort during dwell after the first write
    busy_len = 3; clear_log();
    pulse_start(28'h0000700, 28'h10, 16'd2, 24'd40);
    wait_busy(1'b1, 200);
    wait_busy(1'b0, 200);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_dwell_active", {63'd0, active}, 64'd0);
    tick();
    check("ab_dwell_done", 64'(done_cnt), 64'd0);
    check("ab_dwell_nwr",  64'(wr_fcode.size()), 64'd1);
    m_fsel = PP ? ~m_fsel : 1'b0;
    check("ab_dwell_fsel", {63'd0, ctl.fsel}, {63'd0, m_fsel});

    // abort while fwrq waits for busy
    lat_min = 20; lat_max = 20; clear_log();
    pulse_start(28'h0000900, 28'h1, 16'd1, 24'd1);
    begin
      int k = 0;
      do begin @(negedge clk); k++; end while (!ctl.fwrq && k < 50);
    end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    check("ab_wrq_fwrq",   {63'd0, ctl.fwrq}, 64'd0);
    check("ab_wrq_active", {63'd0, active}, 64'd0);
    check("ab_wrq_nwr",    64'(wr_fcode.size()), 64'd0);
    check("ab_wrq_err",    {63'd0, err}, 64'd0);
    lat_min = 0; lat_max = 2;

    // start and abort together from IDLE
    fwrq_cycles = 0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    check("sa_active", {63'd0, active}, 64'd0);
    check("sa_fwrq",   64'(fwrq_cycles), 64'd0);

    // asynchronous reset in the middle of a dwell
    busy_len = 3; clear_log();
    pulse_start(28'h0000B00, 28'h40, 16'd3, 24'd50);
    wait_busy(1'b1, 200);
    wait_busy(1'b0, 200);
    repeat (5) tick();
    #3 reset = 1'b0;
    #1 check_zero("amid");
    @(negedge clk);
    reset = 1'b1;
    m_fsel = 1'b0;
    tick();
    run_sweep(28'h0000B00, 28'h40, 16'd2, 24'd3);

    check("stable_during_write", 64'(unstable), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ad9837_sweep_seq.md
AD9837_SWEEP_SEQ -- requirements
Module: ad9837_sweep_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 Parameter WR_TIMEOUT, default 64: maximum clk cycles from fwrq rise to busy rise.
REQ-003 Parameter DWELL_W, default 24: width of the dwell count.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle pulse; begins a sweep (ignored unless IDLE).
REQ-007 abort  in  1  single-cycle pulse; terminates the sweep.
REQ-008 f_start  in  28  first FCODE; sampled on accepted start.
REQ-009 f_step  in  28  FCODE increment; sampled on accepted start.
REQ-010 n_steps  in  16  number of increments; total writes = n_steps+1; sampled on start.
REQ-011 dwell  in  DWELL_W  clk cycles held per frequency; sampled on start.
REQ-012 busy  in  1  from AD9837 controller; high while an SPI write is in flight.
REQ-013 FCODE  out  28  frequency word to the controller.
REQ-014 fwrq  out  1  write request to the controller.
REQ-015 fws  out  1  frequency register written (FREQ0/FREQ1).
REQ-016 fsel  out  1  frequency register driving output.
REQ-017 active  out  1  high from accepted start until return to IDLE.
REQ-018 done  out  1  one-cycle pulse on normal completion.
REQ-019 err  out  1  sticky timeout flag, cleared by the next accepted start.
REQ-020 step_idx  out  16  index of the current frequency, 0..n_steps.

Function
REQ-021 States SHALL be: IDLE, LOAD, WRQ, WAIT_DONE, SWAP, DWELL, FINISH.
- IDLE->LOAD: on start with no abort in the same cycle; abort wins over a simultaneous start.
- LOAD: FCODE<=f_start, step_idx<=0, err<=0.
REQ-022 WRQ: fwrq=1 until busy is sampled high, then ->WAIT_DONE.
- If busy is not seen within WR_TIMEOUT cycles: fwrq<=0, err<=1, ->IDLE.
REQ-023 WAIT_DONE: fwrq=0; wait for busy low; ->SWAP.
REQ-024 SWAP: one cycle; toggles fsel to the register just written (Configuration governs this); ->DWELL.
REQ-025 DWELL: counts dwell cycles; dwell=0 SHALL give one cycle.
- At expiry, if step_idx==n_steps ->FINISH.
- Otherwise: FCODE<=FCODE+f_step modulo 2^28 (wrap-around, no saturation), step_idx+1, ->WRQ.
REQ-026 FINISH: done=1 for one cycle; ->IDLE.
REQ-027 Abort in DWELL or LOAD SHALL go to IDLE next cycle; no done pulse.
REQ-028 Abort in WRQ or WAIT_DONE SHALL be latched; the sequencer waits for busy low (an SPI frame is never truncated), skips SWAP, goes to IDLE; no done pulse.
- In WRQ with busy not yet high: fwrq drops immediately, ->IDLE.
REQ-029 FCODE, fws and fsel SHALL change only while fwrq=0 and busy=0.
REQ-030 n_steps=0 SHALL perform exactly one write of f_start, then FINISH after dwell.

Reset
REQ-031 While reset=0: state IDLE, FCODE=0, fwrq=0, fws=0, fsel=0, active=0, done=0, err=0, step_idx=0, dwell counter=0.
REQ-032 Reset SHALL take effect asynchronously mid-sweep; deassertion SHALL be followed by IDLE with no pending write.

Configuration
REQ-033 Macro AD9837_SWEEP_PINGPONG_EN SHALL select the frequency-register scheme.
- Defined: each write targets fws=~fsel; SWAP sets fsel<=fws (glitch-free ping-pong).
- Undefined: fws=0 and fsel=0 permanently; SWAP is a one-cycle no-op.

Verification
REQ-034 f_start=0x0008312, f_step=0x100, n_steps=3, dwell=10, controller model busy=1 for 40 cycles -> four writes: 0x0008312, 0x0008412, 0x0008512, 0x0008612; one done pulse; active low after.
REQ-035 PINGPONG_EN defined, same stimulus -> fws sequence 1,0,1,0; fsel after each SWAP 1,0,1,0; fsel never toggles while busy=1.
REQ-036 f_start=0xFFFFFF0, f_step=0x20, n_steps=1 -> second FCODE=0x0000010 (wrap).
REQ-037 busy tied low -> fwrq high exactly 64 cycles, then err=1, active=0, no done; next start clears err.
REQ-038 abort asserted 5 cycles into busy high -> fwrq stays 0, FCODE is unchanged until busy falls, IDLE with no done; start and abort in the same cycle from IDLE -> remains IDLE.
REQ-039 reset pulsed low during DWELL -> all outputs 0 immediately; a following start sweeps normally from f_start.
